reg_dump_streamer: RTL
======================

# reg_dump_streamer

Debug read-out engine for the 16x8 register bank: on a start pulse it walks a programmable address range through one bank read port and streams a framed byte sequence (header, register bytes, XOR checksum) over a valid/ready byte interface toward the debug/UART transmitter. It is the reader counterpart of the bank's write port, sits beside the core on the bank's second read port, and is idle outside debug dumps.

## Interface

- `NUM_REGS`, 16, number of bank registers; the address space wraps modulo this value.
- `ADDR_W`, 4, register address width.
- `DATA_W`, 8, register and stream byte width.
- `HEADER`, 8'hA5, first byte of every frame.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `first_addr` in ADDR_W: first register of the range, latched on an accepted `start`.
- `last_addr` in ADDR_W: last register of the range, inclusive, latched on an accepted `start`.
- `rd_addr` out ADDR_W: to the bank read address port.
- `rd_data` in DATA_W: combinational bank read data for `rd_addr`.
- `out_valid` out 1: stream byte valid.
- `out_ready` in 1: sink accepts the byte.
- `out_data` out DATA_W: stream byte.
- `out_last` out 1: marks the checksum byte.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse after frame completion.

## Operation

- FSM states: IDLE, HDR, DATA, CSUM.
- A handshake occurs in a cycle where `out_valid` and `out_ready` are both high.
- **IDLE + start:**
  - Latch the range.
  - `ptr <= first_addr`, `remaining <= ((last_addr - first_addr) mod NUM_REGS)`, `csum <= 0`.
  - Load `HEADER` into the output register and go to HDR.
- **HDR handshake:**
  - Load `rd_data` (read at `ptr`) into the output register.
  - `csum ^= rd_data`.
  - Go to DATA.
- **DATA handshake with `remaining != 0`:**
  - `ptr <= ptr + 1`, wrapping 15→0, and decrement `remaining`.
  - Load the next byte the same way as in HDR.
  - The byte is sampled at load time; later bank writes do not alter a loaded byte.
- **DATA handshake with `remaining == 0`:**
  - Load `csum` with `out_last = 1`.
  - Go to CSUM.
- **CSUM handshake:**
  - Clear `out_valid` and `out_last`.
  - Pulse `done`, return to IDLE.
- **`rd_addr`:** equals `ptr` combinationally; in IDLE it holds its last value (0 after reset).
- **Range:** `first_addr > last_addr` wraps, e.g. 14→1 reads 14,15,0,1. `first_addr == last_addr` gives exactly one data byte. Frame length is always remaining+3 bytes.
- **Backpressure:** while `out_valid` is high and `out_ready` is low, `out_data`, `out_last` and `ptr` hold stable. `out_valid` never drops without a handshake.
- **`start` while busy:** ignored; no latch, no effect.
- **Reset values:** `out_valid`, `out_last`, `busy` and `done` are 0; `out_data` is 0; `rd_addr` is 0; state is IDLE.
  - Reset mid-frame aborts the frame immediately.
  - No `done` pulse is produced for an aborted frame.

## Timing

- `start` in cycle 0 gives `busy = 1`, `out_valid = 1` and `out_data = HEADER` in cycle 1.
- With `out_ready` held high, one byte per cycle. The header is accepted in cycle 1 and data bytes in cycles 2..N+1, where N is the number of data bytes (`remaining` + 1). The checksum is accepted in cycle N+2.
- `done = 1` and `busy = 0` in cycle N+3. A new `start` is accepted in that same cycle.
- Data byte k (k = 0..N-1) reflects bank contents at the clock edge that loads it: the edge ending the preceding handshake.

## Structure

- Shared package holds:
  - `NUM_REGS`, `ADDR_W`, `DATA_W`, `HEADER`;
  - the FSM state enum (IDLE/HDR/DATA/CSUM).
- The package is shared with the bank and the debug transmitter.
- Single module. No sub-module: the output register is a few flops inside the FSM, and a separate skid buffer is not warranted.

## Test plan

- **Full dump:** bank reg[i] = 3·i, range 0→15, `out_ready` = 1.
  - Expect 18 consecutive bytes: A5, 00, 03, …, 2D, then XOR of all 16 values.
  - `out_last` only on byte 18; `done` pulse one cycle later.
- **Single register:** range 5→5, reg[5] = 0x3C.
  - Expect A5, 3C, 3C, with `out_last` on the third byte.
- **Wrap:** range 14→1, regs 14, 15, 0, 1 = 11, 22, 33, 44.
  - Expect A5, 11, 22, 33, 44, 44 (checksum = 0x11^0x22^0x33^0x44), with `rd_addr` sequence 14, 15, 0, 1.
- **Backpressure:** `out_ready` low for 3 cycles while byte 3 is presented.
  - `out_data`/`out_valid` stable for all 3 cycles; no byte lost or duplicated.
  - A bank write to an already-loaded register during the stall does not change the byte.
- **Start while busy:** pulse `start` with a new range mid-frame.
  - The frame completes unchanged; exactly one `done`.
- **Reset mid-frame:** drop `rst_n` during DATA.
  - All outputs go to 0 without waiting for a clock; no `done`.
  - A subsequent `start` produces a full, correct frame.

Source files
------------

// File: rtl/reg_dump_streamer_pkg.sv
// Shared definitions for the 16x8 register bank, its dump streamer and the debug transmitter.
// Holds the bank geometry, the frame header byte and the dump FSM state encoding.
package reg_dump_streamer_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam logic [DATA_W-1:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  // Next register address, wrapping at the top of the bank.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return (addr == ADDR_W'(NUM_REGS - 1)) ? '0 : addr + 1'b1;
  endfunction

  // Number of registers after the first one, modulo the bank size.
  function automatic logic [ADDR_W-1:0] range_span(input logic [ADDR_W-1:0] first,
                                                   input logic [ADDR_W-1:0] last);
    return ADDR_W'((int'(last) - int'(first) + NUM_REGS) % NUM_REGS);
  endfunction

endpackage

// File: rtl/reg_dump_streamer.sv
// Walks a register address range through one bank read port and streams
// a framed dump (header, register bytes, XOR checksum) over valid/ready.
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W-1:0]   remaining_reg, remaining_next;
  logic [DATA_W-1:0]   csum_reg, csum_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                valid_reg, valid_next;
  logic                last_reg, last_next;
  logic                done_reg, done_next;
  logic                handshake;

  assign handshake = valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      csum_reg      <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
      csum_reg      <= csum_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      last_reg      <= last_next;
      done_reg      <= done_next;
    end
  end

  // ptr always addresses the register that the next handshake will load,
  // so rd_data is already settled when that handshake edge arrives.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    csum_next      = csum_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    last_next      = last_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          ptr_next       = first_addr;
          remaining_next = range_span(first_addr, last_addr);
          csum_next      = '0;
          data_next      = HEADER;
          valid_next     = 1'b1;
          last_next      = 1'b0;
          state_next     = HDR;
        end
      end
      HDR: begin
        if (handshake) begin
          data_next  = rd_data;
          csum_next  = csum_reg ^ rd_data;
          state_next = DATA;
          if (remaining_reg != '0) begin
            ptr_next = next_addr(ptr_reg);
          end
        end
      end
      DATA: begin
        if (handshake) begin
          if (remaining_reg != '0) begin
            data_next      = rd_data;
            csum_next      = csum_reg ^ rd_data;
            remaining_next = remaining_reg - 1'b1;
            // Stop advancing once the final register has been addressed.
            if (remaining_reg != ADDR_W'(1)) begin
              ptr_next = next_addr(ptr_reg);
            end
          end else begin
            data_next  = csum_reg;
            last_next  = 1'b1;
            state_next = CSUM;
          end
        end
      end
      CSUM: begin
        if (handshake) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: ;
    endcase
  end

  assign rd_addr   = ptr_reg;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_last  = last_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule
